// File: rtl/calc_key_sequencer.sv
// Keypad control stage: decodes keys, accumulates the operand on Num, latches Op,
// and issues one-cycle Sel strobes to the operand holders.
//
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   key_valid, key_code key event (0-9 digit, 10-13 op, 14 '=', 15 'C')
//   Num                 operand bus to holder data inputs
//   Sel                 000 none, 001 load A, 010 load B, 011 execute, 100 clear
//   Op                  latched operator (00 +, 01 -, 10 *, 11 &)
//   ovf                 sticky saturation flag for the current operand
//   busy                high in LOAD_B / EXEC
//
// Build option: define CALC_DIGIT_LIMIT_EN to cap operand entry at 3 digits.
module calc_key_sequencer #(
  parameter int MAX_VAL = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [7:0] Num,
  output logic [2:0] Sel,
  output logic [1:0] Op,
  output logic       ovf,
  output logic       busy
);

  localparam logic [2:0] S_ENTER_A = 3'd0;
  localparam logic [2:0] S_ENTER_B = 3'd1;
  localparam logic [2:0] S_LOAD_B  = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_RESULT  = 3'd4;

  localparam logic [2:0] SEL_NONE  = 3'b000;
  localparam logic [2:0] SEL_LD_A  = 3'b001;
  localparam logic [2:0] SEL_LD_B  = 3'b010;
  localparam logic [2:0] SEL_EXEC  = 3'b011;
  localparam logic [2:0] SEL_CLEAR = 3'b100;

  localparam logic [11:0] MAX12 = 12'(MAX_VAL);
  localparam logic [7:0]  MAX8  = 8'(MAX_VAL);

  logic [2:0]  state;
  logic [2:0]  state_n;
  logic [7:0]  num_n;
  logic [2:0]  sel_n;
  logic [1:0]  op_n;
  logic        ovf_n;
  logic        busy_n;

  // clr: operand A was just strobed out; wipe Num/ovf on this cycle
  logic        clr;
  logic        clr_n;

  logic [1:0]  digs;
  logic [1:0]  digs_n;

  logic        is_digit;
  logic        is_op;
  logic        is_eq;
  logic        is_clr;

  logic [7:0]  base;
  logic        base_ovf;
  logic [1:0]  base_digs;
  logic [11:0] acc;
  logic        dig_ok;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_op    = key_valid && (key_code >= 4'd10)
                              && (key_code <= 4'd13);
  assign is_eq    = key_valid && (key_code == 4'd14);
  assign is_clr   = key_valid && (key_code == 4'd15);

  // operand view after any pending post-strobe clear
  assign base      = clr ? 8'd0 : Num;
  assign base_ovf  = clr ? 1'b0 : ovf;
  assign base_digs = clr ? 2'd0 : digs;

  // 12 bits holds 255*10+9 without wrap
  assign acc = {4'd0, base} * 12'd10 + {8'd0, key_code};

`ifdef CALC_DIGIT_LIMIT_EN
  assign dig_ok = (base_digs != 2'd3);
`else
  assign dig_ok = 1'b1;
`endif

  always_comb begin
    state_n = state;
    num_n   = base;
    sel_n   = SEL_NONE;
    op_n    = Op;
    ovf_n   = base_ovf;
    clr_n   = 1'b0;
    digs_n  = base_digs;

    if (is_clr) begin
      state_n = S_ENTER_A;
      num_n   = 8'd0;
      sel_n   = SEL_CLEAR;
      op_n    = 2'b00;
      ovf_n   = 1'b0;
      digs_n  = 2'd0;
    end else begin
      case (state)
        S_ENTER_A, S_ENTER_B: begin
          if (is_digit) begin
            if (dig_ok) begin
              digs_n = base_digs + 2'd1;
              if (acc > MAX12) begin
                num_n = MAX8;
                ovf_n = 1'b1;
              end else begin
                num_n = acc[7:0];
              end
            end
          end else if (is_op) begin
            op_n = key_code[1:0] - 2'd2;
            if (state == S_ENTER_A) begin
              sel_n   = SEL_LD_A;
              num_n   = Num;
              ovf_n   = ovf;
              clr_n   = 1'b1;
              digs_n  = 2'd0;
              state_n = S_ENTER_B;
            end
          end else if (is_eq && state == S_ENTER_B) begin
            sel_n   = SEL_LD_B;
            state_n = S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          sel_n   = SEL_EXEC;
          state_n = S_EXEC;
        end
        S_EXEC: begin
          num_n   = 8'd0;
          state_n = S_RESULT;
        end
        S_RESULT: begin
          if (is_digit) begin
            num_n   = {4'd0, key_code};
            ovf_n   = 1'b0;
            digs_n  = 2'd1;
            state_n = S_ENTER_A;
          end else if (is_op) begin
            op_n    = key_code[1:0] - 2'd2;
            sel_n   = SEL_LD_A;
            num_n   = 8'd0;
            clr_n   = 1'b1;
            digs_n  = 2'd0;
            state_n = S_ENTER_B;
          end
        end
        default: begin
          state_n = S_ENTER_A;
          num_n   = 8'd0;
          ovf_n   = 1'b0;
          digs_n  = 2'd0;
        end
      endcase
    end

    busy_n = (state_n == S_LOAD_B) || (state_n == S_EXEC);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_ENTER_A;
      Num   <= 8'd0;
      Sel   <= SEL_NONE;
      Op    <= 2'b00;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      clr   <= 1'b0;
      digs  <= 2'd0;
    end else begin
      state <= state_n;
      Num   <= num_n;
      Sel   <= sel_n;
      Op    <= op_n;
      ovf   <= ovf_n;
      busy  <= busy_n;
      clr   <= clr_n;
      digs  <= digs_n;
    end
  end

endmodule
